// File: rtl/truth_table_sweeper_pkg.sv
// ============================================================================
//  Module      : truth_table_sweeper_pkg
//  Description : Shared state encoding and sizing helper for the sweeper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_sweep_settle_counter.sv
// ============================================================================
//  Module      : sweep_settle_counter
//  Description : Loadable down-counter that stops at zero and flags it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_settle_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Exhaustive truth-table stimulus and checker for small
//                combinational DUTs; logs each vector and keeps error stats.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                          N_IN          = 4,
    parameter int                          N_OUT         = 1,
    parameter int                          SETTLE_CYCLES = 1,
    parameter int                          STOP_ON_FAIL  = 0,
    parameter logic [N_OUT*(2**N_IN)-1:0]  EXPECTED      = 16'h7FFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_idx,
    output logic             log_valid,
    output logic [N_IN-1:0]  log_idx,
    output logic [N_OUT-1:0] log_out
);

    localparam int              c_n_vec       = 2 ** N_IN;
    localparam int              c_cnt_w       = cnt_width(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [N_IN:0]   c_last_idx    = (N_IN + 1)'(c_n_vec - 1);

    sweep_state_t     r_state;
    sweep_state_t     w_next_state;

    logic [N_IN-1:0]  r_idx;
    logic [N_IN:0]    r_err;
    logic             r_ffv;
    logic [N_IN-1:0]  r_ffi;
    logic             r_done;
    logic             r_pass;
    logic             r_busy;
    logic             r_log_valid;
    logic [N_IN-1:0]  r_log_idx;
    logic [N_OUT-1:0] r_log_out;

    int               w_exp_base;
    logic [N_OUT-1:0] w_expected;
    logic             w_mismatch;
    logic             w_last;
    logic             w_finish;
    logic             w_start_ok;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_settled;

    assign w_exp_base = int'(r_idx) * N_OUT;
    assign w_expected = EXPECTED[w_exp_base +: N_OUT];
    assign w_mismatch = (dut_out != w_expected);
    // Full-width compare so the index can never wrap back to zero.
    assign w_last     = ({1'b0, r_idx} == c_last_idx);
    assign w_finish   = w_last || (w_mismatch && (STOP_ON_FAIL != 0));
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_load = w_start_ok || ((r_state == ST_CHECK) && !w_finish);
    assign w_cnt_dec  = (r_state == ST_SETTLE);

    sweep_settle_counter #(
        .WIDTH (c_cnt_w)
    ) u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (c_settle_load),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_settled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next_state = ST_SETTLE;
            ST_SETTLE:        if (w_settled) w_next_state = ST_CHECK;
            ST_CHECK:         w_next_state = w_finish ? ST_DONE : ST_SETTLE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_err       <= '0;
            r_ffv       <= 1'b0;
            r_ffi       <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b0;
            r_log_valid <= 1'b0;
            r_log_idx   <= '0;
            r_log_out   <= '0;
        end else begin
            r_busy      <= (w_next_state == ST_SETTLE) || (w_next_state == ST_CHECK);
            r_log_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_idx  <= '0;
                        r_err  <= '0;
                        r_ffv  <= 1'b0;
                        r_ffi  <= '0;
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_log_valid <= 1'b1;
                    r_log_idx   <= r_idx;
                    r_log_out   <= dut_out;
                    if (w_mismatch) begin
                        r_err <= r_err + 1'b1;
                        if (!r_ffv) begin
                            r_ffv <= 1'b1;
                            r_ffi <= r_idx;
                        end
                    end
                    if (w_finish) begin
                        r_done <= 1'b1;
                        r_pass <= !w_mismatch && (r_err == '0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in           = r_idx;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_idx   = r_ffi;
    assign log_valid        = r_log_valid;
    assign log_idx          = r_log_idx;
    assign log_out          = r_log_out;

endmodule

`default_nettype wire
